// File: rtl/zxw_8bit_dncnt_timer_pkg.sv
// Shared definitions for the down-counting timer: state encoding and default width.
// Latency: n/a (package). Backpressure: n/a.
package zxw_8bit_dncnt_timer_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // A state that accepts Start, i.e. anything other than an active countdown.
    function automatic logic start_ok(input state_t s);
        return (s != S_RUN);
    endfunction

endpackage

// File: rtl/zxw_nbit_dncnt_v.sv
// Datapath down counter: synchronous load, decrement, or hold; load beats decrement.
// Latency: one cycle from command to o_q. Backpressure: none, decrement saturates at zero.
module zxw_nbit_dncnt_v
    import zxw_8bit_dncnt_timer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_q,
    output logic             o_is_one,
    output logic             o_is_zero
);

    logic [WIDTH-1:0] r_q;
    logic             w_zero;

    assign w_zero = (r_q == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_dec && !w_zero) begin
            // Guarded so the count can never wrap below zero.
            r_q <= r_q - 1'b1;
        end
    end

    assign o_q       = r_q;
    assign o_is_zero = w_zero;
    assign o_is_one  = (r_q == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/zxw_8bit_dncnt_timer.sv
// Programmable down-count timer with one-shot and periodic auto-reload modes.
// Latency: Q/Busy/Done/TC registered, one cycle after the controlling edge. Backpressure: none.
module zxw_8bit_dncnt_timer
    import zxw_8bit_dncnt_timer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_ld_en,
    input  logic             i_start,
    input  logic             i_cnt_en,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_q,
    output logic             o_tc,
    output logic             o_busy,
    output logic             o_done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             r_tc;
    logic             w_tc_nxt;
    logic             r_busy;
    logic             r_done;

    logic             w_load;
    logic [WIDTH-1:0] w_load_val;
    logic             w_dec;
    logic [WIDTH-1:0] w_q;
    logic             w_q_is_one;
    logic             w_q_is_zero;
    logic             w_reload_zero;

    assign w_reload_zero = (r_reload == '0);

    zxw_nbit_dncnt_v #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_q        (w_q),
        .o_is_one   (w_q_is_one),
        .o_is_zero  (w_q_is_zero)
    );

    // Priority below reset: LD_EN, then Start, then Cnt_EN.
    always_comb begin
        w_state_nxt  = r_state;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;
        w_load       = 1'b0;
        w_load_val   = r_reload;
        w_dec        = 1'b0;

        if (i_ld_en) begin
            w_reload_nxt = i_d;
            w_load       = 1'b1;
            w_load_val   = i_d;
            w_state_nxt  = S_IDLE;
        end else if (i_start && start_ok(r_state)) begin
            w_load     = 1'b1;
            w_load_val = r_reload;
            if (w_reload_zero) begin
                w_state_nxt = S_DONE;
                w_tc_nxt    = 1'b1;
            end else begin
                w_state_nxt = S_RUN;
            end
        end else if (r_state == S_RUN && i_cnt_en) begin
            if (w_q_is_one) begin
                w_tc_nxt = 1'b1;
                w_load   = 1'b1;
                if (i_mode) begin
                    w_load_val = r_reload;
                end else begin
                    w_load_val  = '0;
                    w_state_nxt = S_DONE;
                end
            end else begin
                w_dec = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_reload <= '0;
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_reload <= w_reload_nxt;
            r_tc     <= w_tc_nxt;
            r_busy   <= (w_state_nxt == S_RUN);
            r_done   <= (w_state_nxt == S_DONE);
        end
    end

    assign o_q    = w_q;
    assign o_tc   = r_tc;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_zxw_8bit_dncnt_timer.sv
// Self-checking bench for zxw_8bit_dncnt_timer: behavioural reference plus scenario checks.
module tb_zxw_8bit_dncnt_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d;
    logic       ld_en, start, cnt_en, mode;
    logic [7:0] q;
    logic       tc, busy, done;

    always #5 clk = ~clk;

    zxw_8bit_dncnt_timer #(.WIDTH(8)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_d      (d),
        .i_ld_en  (ld_en),
        .i_start  (start),
        .i_cnt_en (cnt_en),
        .i_mode   (mode),
        .o_q      (q),
        .o_tc     (tc),
        .o_busy   (busy),
        .o_done   (done)
    );

    typedef struct {
        int q;
        int tc;
        int busy;
        int done;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Reference: phase 0=idle, 1=counting, 2=finished.
    int m_q = 0, m_r = 0, m_ph = 0, m_tc = 0;

    int obs_q, obs_tc, obs_busy, obs_done;

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit ld, input int dv, input bit st,
                              input bit ce, input bit md);
        if (r) begin
            m_q = 0; m_r = 0; m_ph = 0; m_tc = 0;
        end else if (ld) begin
            m_r = dv; m_q = dv; m_ph = 0; m_tc = 0;
        end else if (st && m_ph != 1) begin
            m_q  = m_r;
            m_tc = (m_r == 0) ? 1 : 0;
            m_ph = (m_r == 0) ? 2 : 1;
        end else if (m_ph == 1 && ce) begin
            if (m_q == 1) begin
                m_tc = 1;
                if (md) m_q = m_r;
                else begin
                    m_q = 0; m_ph = 2;
                end
            end else begin
                m_q  = m_q - 1;
                m_tc = 0;
            end
        end else begin
            m_tc = 0;
        end
    endtask

    task automatic step(input bit r, input bit ld, input int dv, input bit st,
                        input bit ce, input bit md);
        exp_t e;
        @(negedge clk);
        rst = r; ld_en = ld; d = dv[7:0]; start = st; cnt_en = ce; mode = md;
        model_edge(r, ld, dv, st, ce, md);
        e.q = m_q; e.tc = m_tc; e.busy = (m_ph == 1); e.done = (m_ph == 2);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            obs_q = int'(q); obs_tc = int'(tc); obs_busy = int'(busy); obs_done = int'(done);
            check_val("q", obs_q, e.q);
            check_val("tc", obs_tc, e.tc);
            check_val("busy", obs_busy, e.busy);
            check_val("done", obs_done, e.done);
        end
    endtask

    int tc_cnt, busy_cnt, en_cnt, tc_at;
    int seq[5];

    initial begin
        rst = 1'b1; d = '0; ld_en = 1'b0; start = 1'b0; cnt_en = 1'b0; mode = 1'b0;

        // Reset state
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check_val("rst_q", obs_q, 0);
        check_val("rst_busy", obs_busy, 0);
        check_val("rst_done", obs_done, 0);

        // One-shot D=5
        step(0, 1, 5, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        check_val("os_start_q", obs_q, 5);
        check_val("os_start_busy", obs_busy, 1);
        tc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1, 0);
            seq[i] = obs_q;
            tc_cnt += obs_tc;
        end
        for (int i = 0; i < 5; i++) check_val("os_seq", seq[i], 4 - i);
        check_val("os_tc_cnt", tc_cnt, 1);
        check_val("os_tc_last", obs_tc, 1);
        check_val("os_done", obs_done, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 0);
        check_val("os_hold_q", obs_q, 0);

        // Periodic D=3 with Cnt_EN toggling
        step(0, 1, 3, 0, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        tc_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 0, 0, (i % 2 == 0), 1);
            tc_cnt += obs_tc;
            busy_cnt += obs_busy;
        end
        check_val("per_tc_cnt", tc_cnt, 5);
        check_val("per_busy_cnt", busy_cnt, 30);

        // LD_EN at Q=1 while counting, then Start+LD_EN
        step(0, 1, 4, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
        check_val("sim_pre_q", obs_q, 1);
        step(0, 1, 8, 0, 1, 0);
        check_val("sim_ld_q", obs_q, 8);
        check_val("sim_ld_tc", obs_tc, 0);
        check_val("sim_ld_busy", obs_busy, 0);
        step(0, 1, 2, 1, 1, 0);
        check_val("sim_ldst_busy", obs_busy, 0);
        check_val("sim_ldst_q", obs_q, 2);

        // R=0 and R=1 boundaries
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check_val("r0_done", obs_done, 1);
        check_val("r0_tc", obs_tc, 1);
        step(0, 0, 0, 0, 1, 0);
        check_val("r0_tc_next", obs_tc, 0);
        step(0, 1, 1, 0, 0, 1);
        step(0, 0, 0, 1, 1, 1);
        tc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1, 1);
            tc_cnt += obs_tc;
        end
        check_val("r1_tc_cnt", tc_cnt, 5);
        check_val("r1_q", obs_q, 1);

        // Reset mid-countdown
        step(0, 1, 10, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
        check_val("mr_pre_q", obs_q, 6);
        step(1, 0, 0, 0, 1, 0);
        check_val("mr_q", obs_q, 0);
        check_val("mr_tc", obs_tc, 0);
        check_val("mr_busy", obs_busy, 0);
        step(0, 0, 0, 1, 0, 0);
        check_val("mr_start_done", obs_done, 1);
        check_val("mr_start_tc", obs_tc, 1);

        // Start while busy is ignored
        step(0, 1, 20, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        en_cnt = 0; tc_at = -1;
        for (int i = 0; i < 40 && tc_at < 0; i++) begin
            step(0, 0, 0, (en_cnt == 8), 1, 0);
            en_cnt++;
            if (en_cnt == 9) check_val("sb_q_after_start", obs_q, 11);
            if (obs_tc == 1) tc_at = en_cnt;
        end
        check_val("sb_tc_at", tc_at, 20);

        // Random traffic against the reference
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 60) == 0), ($urandom_range(0, 15) == 0),
                 int'($urandom_range(0, 6)), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 1));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
